// File: rtl/rv4028_bus_arbiter_if.sv
// rtl/rv4028_bus_arbiter_if.sv - RV4028 external bus arbitration signal bundle
interface rv4028_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    logic                   busrq_n;
    logic                   busack_n;
    logic [NUM_MASTERS-1:0] dma_req;
    logic [NUM_MASTERS-1:0] dma_grant;
    logic [NUM_MASTERS-1:0] dma_yield;
    logic [3:0]             bus_owner;

    // Arbiter side: drives the core request and the per-master grants.
    modport master (
        output busrq_n,
        output dma_grant,
        output dma_yield,
        output bus_owner,
        input  busack_n,
        input  dma_req
    );

    // Environment side: the core acknowledge and the DMA requesters.
    modport slave (
        input  busrq_n,
        input  dma_grant,
        input  dma_yield,
        input  bus_owner,
        output busack_n,
        output dma_req
    );
endinterface

// File: rtl/rv4028_bus_arbiter.sv
// rtl/rv4028_bus_arbiter.sv - round-robin arbiter sharing the RV4028 bus between CPU and DMA masters
module rv4028_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_HOLD    = 64,
    parameter int TURNAROUND  = 1,
    parameter int MIN_CPU     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv4028_bus_arbiter_if.master bus
);
    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 2);
    localparam logic [NUM_MASTERS-1:0] ONE = 1;
    localparam logic [3:0] OWNER_CPU   = 4'd0;
    localparam logic [3:0] OWNER_TRANS = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        TURN_IN,
        GRANT,
        TURN_OUT,
        RELEASE
    } state_t;

    state_t                 state_q,  state_nxt;
    logic [IDX_W-1:0]       win_q,    win_nxt;
    logic [IDX_W-1:0]       last_q,   last_nxt;
    logic [7:0]             cpu_q,    cpu_nxt;
    logic [3:0]             turn_q,   turn_nxt;
    logic [HOLD_W-1:0]      hold_q,   hold_nxt;
    logic                   busrq_q,  busrq_nxt;
    logic [NUM_MASTERS-1:0] grant_q,  grant_nxt;
    logic [NUM_MASTERS-1:0] yield_q,  yield_nxt;
    logic [3:0]             owner_q,  owner_nxt;

    logic [IDX_W-1:0]       pick;
    logic                   pick_found;

    // Round-robin search: first requester after the last granted index, wrapping.
    always_comb begin
        int j;
        j          = 0;
        pick       = last_q;
        pick_found = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            j = int'(last_q) + i;
            if (j >= NUM_MASTERS) begin
                j = j - NUM_MASTERS;
            end
            if (!pick_found && bus.dma_req[IDX_W'(j)]) begin
                pick       = IDX_W'(j);
                pick_found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; every ownership change goes via the CPU.
    always_comb begin
        state_nxt = state_q;
        win_nxt   = win_q;
        last_nxt  = last_q;
        cpu_nxt   = cpu_q;
        turn_nxt  = turn_q;
        hold_nxt  = hold_q;
        busrq_nxt = busrq_q;
        grant_nxt = grant_q;
        yield_nxt = yield_q;
        owner_nxt = owner_q;
        case (state_q)
            IDLE: begin
                if (cpu_q != 8'd0) begin
                    cpu_nxt = cpu_q - 8'd1;
                end else if (pick_found) begin
                    win_nxt   = pick;
                    busrq_nxt = 1'b0;
                    owner_nxt = OWNER_TRANS;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!bus.busack_n) begin
                    turn_nxt  = 4'(TURNAROUND - 1);
                    state_nxt = TURN_IN;
                end else if (!bus.dma_req[win_q]) begin
                    busrq_nxt = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            TURN_IN: begin
                if (turn_q == 4'd0) begin
                    grant_nxt = ONE << win_q;
                    owner_nxt = 4'(win_q) + 4'd1;
                    hold_nxt  = '0;
                    last_nxt  = win_q;
                    state_nxt = GRANT;
                end else begin
                    turn_nxt = turn_q - 4'd1;
                end
            end
            GRANT: begin
                if (bus.busack_n) begin
                    // Core let go of the bus under us: stop driving immediately.
                    grant_nxt = '0;
                    yield_nxt = '0;
                    owner_nxt = OWNER_TRANS;
                    busrq_nxt = 1'b1;
                    state_nxt = RELEASE;
                end else if (!bus.dma_req[win_q]) begin
                    grant_nxt = '0;
                    yield_nxt = '0;
                    owner_nxt = OWNER_TRANS;
                    turn_nxt  = 4'(TURNAROUND - 1);
                    state_nxt = TURN_OUT;
                end else begin
                    if (hold_q != '1) begin
                        hold_nxt = hold_q + 1'b1;
                    end
                    // Yield is only a hint; the grant is held until the master lets go.
                    if ((MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD - 1))) begin
                        yield_nxt = ONE << win_q;
                    end
                end
            end
            TURN_OUT: begin
                if (turn_q == 4'd0) begin
                    busrq_nxt = 1'b1;
                    state_nxt = RELEASE;
                end else begin
                    turn_nxt = turn_q - 4'd1;
                end
            end
            RELEASE: begin
                if (bus.busack_n) begin
                    cpu_nxt   = 8'(MIN_CPU);
                    owner_nxt = OWNER_CPU;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
            cpu_q   <= 8'd0;
            turn_q  <= 4'd0;
            hold_q  <= '0;
            busrq_q <= 1'b1;
            grant_q <= '0;
            yield_q <= '0;
            owner_q <= OWNER_CPU;
        end else begin
            state_q <= state_nxt;
            win_q   <= win_nxt;
            last_q  <= last_nxt;
            cpu_q   <= cpu_nxt;
            turn_q  <= turn_nxt;
            hold_q  <= hold_nxt;
            busrq_q <= busrq_nxt;
            grant_q <= grant_nxt;
            yield_q <= yield_nxt;
            owner_q <= owner_nxt;
        end
    end

    assign bus.busrq_n   = busrq_q;
    assign bus.dma_grant = grant_q;
    assign bus.dma_yield = yield_q;
    assign bus.bus_owner = owner_q;
endmodule
